pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, is the maximum number of FETCH cycles without imem_ack before a fault is raised (range 2..255).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc  input  32  current program counter value from the ProgramCounter block.
REQ-005 stall  input  1  holds the sequencer before starting a new fetch.
REQ-006 imem_req  output  1  instruction memory request, level, held until ack.
REQ-007 imem_addr  output  32  fetch address, equals pc while imem_req=1, else 0.
REQ-008 imem_ack  input  1  one-cycle memory acknowledge; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  fetched instruction available to the core.
REQ-011 instr  output  32  latched instruction word, stable while instr_valid=1.
REQ-012 instr_ready  input  1  core accepts instr; branch_taken and branch_offset are sampled in the same cycle.
REQ-013 branch_taken  input  1  1 = next PC is pc+branch_offset.
REQ-014 branch_offset  input  32  signed byte offset for a taken branch or jump.
REQ-015 pc_inc  output  1  one-cycle pulse commanding the ProgramCounter to update.
REQ-016 pc_sel  output  1  0 = sequential increment, 1 = branch offset; valid with pc_inc.
REQ-017 pc_incr  output  32  increment applied to pc: 32'd4 when pc_sel=0, branch_offset as captured when pc_sel=1; 0 when pc_inc=0.
REQ-018 fault  output  1  sticky error flag, cleared only by reset.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, ISSUE, UPDATE and FAULT, one-hot or encoded.
REQ-020 IDLE: all handshake outputs are 0; IDLE goes to FETCH when stall=0, else stays in IDLE.
REQ-021 On FETCH entry with pc[1:0]!=0, the FSM SHALL go to FAULT without asserting imem_req.
REQ-022 FETCH: imem_req=1 and imem_addr=pc every cycle; on imem_ack=1, imem_rdata is latched into instr and the FSM goes to ISSUE.
REQ-023 A wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; reaching TIMEOUT_CYC without ack goes to FAULT, and an ack in that same cycle wins.
REQ-024 ISSUE: instr_valid=1 with instr held; on instr_ready=1, branch_taken and branch_offset are registered and the FSM goes to UPDATE; otherwise it stays in ISSUE indefinitely.
REQ-025 UPDATE lasts exactly one cycle: pc_inc=1, pc_sel=registered branch_taken, and pc_incr per REQ-017.
REQ-026 UPDATE exit: go to FETCH if stall=0, else to IDLE.
REQ-027 Latency: ack in cycle N gives instr_valid in N+1; instr_ready in cycle M gives pc_inc in M+1 and the next imem_req in M+2, with the updated pc.
REQ-028 pc_inc SHALL never be asserted in two consecutive cycles, and exactly one pulse occurs per accepted instruction.
REQ-029 imem_ack outside FETCH SHALL be ignored; it does not change state or instr.
REQ-030 stall SHALL be sampled only in IDLE and UPDATE; it never aborts an outstanding request or a pending ISSUE.
REQ-031 FAULT: fault=1, all other outputs are 0, and the FSM stays in FAULT until reset.
REQ-032 The branch target is not checked in UPDATE; its misalignment is detected at the next FETCH entry (REQ-021).

Reset
REQ-033 reset=1 at any rising edge SHALL force IDLE and clear the wait counter, instr, the registered branch fields and fault.
REQ-034 During reset and in the first cycle after it, all outputs SHALL be 0.
REQ-035 Reset asserted mid-FETCH drops imem_req at the next edge, and any later ack for that request is ignored.

Verification
REQ-036 Sequential flow: pc=0x0, ack after 2 cycles with rdata=0x00500093, ready at once with taken=0 -> instr=0x00500093; pc_inc=1, pc_sel=0, pc_incr=4; next imem_addr=0x4.
REQ-037 Taken branch: pc=0x10, ready with taken=1 and offset=0xFFFFFFF8 -> pc_sel=1, pc_incr=0xFFFFFFF8; next fetch at 0x8.
REQ-038 Backpressure: ready held low for 5 cycles in ISSUE -> instr_valid and instr stable and no pc_inc until the cycle after ready.
REQ-039 Timeout: with TIMEOUT_CYC=16 and no ack -> fault=1 after 16 FETCH cycles, imem_req=0 after that, and fault stays set until reset.
REQ-040 Misaligned: pc=0x6 on FETCH entry -> no imem_req and fault=1 the next cycle.
REQ-041 Stall and reset: stall=1 during UPDATE -> IDLE with no request; then reset during FETCH followed by a late ack -> all outputs 0 and instr unchanged at 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: fetches from instruction memory at pc, hands the
// word to the core, then commands the ProgramCounter with a sequential or branch increment.
module pc_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic        pc_inc,
  output logic        pc_sel,
  output logic [31:0] pc_incr,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_UPDATE,
    S_FAULT
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] offset_q, offset_d;
  logic        taken_q, taken_d;

  logic        req_c;
  logic        valid_c;
  logic        inc_c;
  logic        sel_c;
  logic [31:0] incr_c;
  logic        fault_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      instr_q  <= '0;
      offset_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      instr_q  <= instr_d;
      offset_q <= offset_d;
      taken_q  <= taken_d;
    end
  end

  // wait_q == 0 marks the first FETCH cycle, where pc alignment is judged.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    instr_d  = instr_q;
    offset_d = offset_q;
    taken_d  = taken_q;
    req_c    = 1'b0;
    valid_c  = 1'b0;
    inc_c    = 1'b0;
    sel_c    = 1'b0;
    incr_c   = '0;
    fault_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!stall) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end

      S_FETCH: begin
        if (wait_q == 8'd0 && pc[1:0] != 2'b00) begin
          state_d = S_FAULT;
        end else begin
          req_c = 1'b1;
          if (imem_ack) begin
            instr_d = imem_rdata;
            state_d = S_ISSUE;
          end else if (wait_q == LAST_WAIT) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end

      S_ISSUE: begin
        valid_c = 1'b1;
        if (instr_ready) begin
          taken_d  = branch_taken;
          offset_d = branch_offset;
          state_d  = S_UPDATE;
        end
      end

      S_UPDATE: begin
        inc_c  = 1'b1;
        sel_c  = taken_q;
        incr_c = taken_q ? offset_q : 32'd4;
        if (stall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end

      S_FAULT: begin
        fault_c = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks before the edge.
  assign imem_req    = req_c & ~reset;
  assign imem_addr   = imem_req ? pc : 32'd0;
  assign instr_valid = valid_c & ~reset;
  assign instr       = (reset || state_q == S_FAULT) ? 32'd0 : instr_q;
  assign pc_inc      = inc_c & ~reset;
  assign pc_sel      = sel_c & ~reset;
  assign pc_incr     = reset ? 32'd0 : incr_c;
  assign fault       = fault_c & ~reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential flow, branches,
// backpressure, timeout, misalignment, stall and reset behaviour.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        pc_inc;
  logic        pc_sel;
  logic [31:0] pc_incr;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_inc        (pc_inc),
    .pc_sel        (pc_sel),
    .pc_incr       (pc_incr),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge; inputs change and outputs are sampled 2 time units later.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; pc = 32'h0; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    cycle();
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, pc_sel, fault} !== 5'b0 || imem_addr !== 32'd0 ||
        instr !== 32'd0 || pc_incr !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_during: req=%0b valid=%0b inc=%0b fault=%0b addr=%h instr=%h incr=%h, want all 0",
               imem_req, instr_valid, pc_inc, fault, imem_addr, instr, pc_incr);
    end
    stall = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, pc_sel, fault} !== 5'b0 || imem_addr !== 32'd0 ||
        instr !== 32'd0 || pc_incr !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_after: req=%0b valid=%0b inc=%0b fault=%0b addr=%h instr=%h incr=%h, want all 0",
               imem_req, instr_valid, pc_inc, fault, imem_addr, instr, pc_incr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    pc = 32'h0; stall = 1'b0;
    cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL seq_fetch1: req=%0b addr=%h, want 1 / 00000000", imem_req, imem_addr);
    end
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'h00500093;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL seq_fetch2: req=%0b valid=%0b, want 1 / 0", imem_req, instr_valid);
    end
    cycle();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b1; branch_taken = 1'b0; branch_offset = 32'h00000123;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00500093 || imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL seq_issue: valid=%0b instr=%h req=%0b, want 1 / 00500093 / 0",
               instr_valid, instr, imem_req);
    end
    cycle();
    instr_ready = 1'b0; branch_offset = 32'h0;
    #1;
    n_checks++;
    if (pc_inc !== 1'b1 || pc_sel !== 1'b0 || pc_incr !== 32'd4 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL seq_update: inc=%0b sel=%0b incr=%h valid=%0b, want 1 / 0 / 00000004 / 0",
               pc_inc, pc_sel, pc_incr, instr_valid);
    end
    cycle();
    pc = 32'h4;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || pc_inc !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL seq_next_fetch: req=%0b addr=%h inc=%0b, want 1 / 00000004 / 0",
               imem_req, imem_addr, pc_inc);
    end
  endtask

  task automatic test_branch();
    do_reset();
    pc = 32'h10; stall = 1'b0;
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'hFE000EE3;
    cycle();
    imem_ack = 1'b0;
    instr_ready = 1'b1; branch_taken = 1'b1; branch_offset = 32'hFFFFFFF8;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hFE000EE3) begin
      n_fail++;
      $display("[TB] FAIL br_issue: valid=%0b instr=%h, want 1 / fe000ee3", instr_valid, instr);
    end
    cycle();
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
    #1;
    n_checks++;
    if (pc_inc !== 1'b1 || pc_sel !== 1'b1 || pc_incr !== 32'hFFFFFFF8) begin
      n_fail++;
      $display("[TB] FAIL br_update: inc=%0b sel=%0b incr=%h, want 1 / 1 / fffffff8",
               pc_inc, pc_sel, pc_incr);
    end
    cycle();
    pc = 32'h8;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fault !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL br_next_fetch: req=%0b addr=%h fault=%0b, want 1 / 00000008 / 0",
               imem_req, imem_addr, fault);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    pc = 32'h20; stall = 1'b0;
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    cycle();
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h11111111;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 32'hDEADBEEF || pc_inc !== 1'b0 || imem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold[%0d]: valid=%0b instr=%h inc=%0b req=%0b, want 1 / deadbeef / 0 / 0",
                 k, instr_valid, instr, pc_inc, imem_req);
      end
      cycle();
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1; branch_taken = 1'b0;
    #1;
    n_checks++;
    if (pc_inc !== 1'b0 || instr_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_ready_cycle: inc=%0b valid=%0b, want 0 / 1", pc_inc, instr_valid);
    end
    cycle();
    instr_ready = 1'b0;
    #1;
    n_checks++;
    if (pc_inc !== 1'b1 || pc_sel !== 1'b0 || pc_incr !== 32'd4) begin
      n_fail++;
      $display("[TB] FAIL bp_update: inc=%0b sel=%0b incr=%h, want 1 / 0 / 00000004", pc_inc, pc_sel, pc_incr);
    end
    cycle();
    pc = 32'h24;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || pc_inc !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL stall_idle: req=%0b inc=%0b valid=%0b instr=%h, want 0 / 0 / 0 / deadbeef",
               imem_req, pc_inc, instr_valid, instr);
    end
    cycle();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL stall_idle2: req=%0b addr=%h, want 0 / 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    pc = 32'h40; stall = 1'b0;
    cycle();
    for (int i = 1; i <= 16; i++) begin
      if (imem_req !== 1'b1 || fault !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL to_wait[%0d]: req=%0b fault=%0b, want 1 / 0", i, imem_req, fault);
      end
      n_checks++;
      cycle();
    end
    imem_ack = 1'b1; imem_rdata = 32'h22222222; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fault !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'd0 ||
          instr_valid !== 1'b0 || pc_inc !== 1'b0 || instr !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL to_fault[%0d]: fault=%0b req=%0b addr=%h valid=%0b inc=%0b instr=%h, want 1 / 0 / 0 / 0 / 0 / 0",
                 i, fault, imem_req, imem_addr, instr_valid, pc_inc, instr);
      end
      stall = (i == 1);
      cycle();
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    do_reset();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL to_cleared: fault=%0b, want 0", fault);
    end
  endtask

  task automatic test_timeout_ack_wins();
    do_reset();
    pc = 32'h44; stall = 1'b0;
    cycle();
    for (int i = 1; i < 16; i++) cycle();
    imem_ack = 1'b1; imem_rdata = 32'h33333333;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || fault !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tack_last_fetch: req=%0b fault=%0b, want 1 / 0", imem_req, fault);
    end
    cycle();
    imem_ack = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h33333333 || fault !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tack_issue: valid=%0b instr=%h fault=%0b, want 1 / 33333333 / 0",
               instr_valid, instr, fault);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    pc = 32'h6; stall = 1'b0;
    cycle();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || fault !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mis_entry: req=%0b addr=%h fault=%0b, want 0 / 0 / 0", imem_req, imem_addr, fault);
    end
    cycle();
    n_checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mis_fault: fault=%0b req=%0b, want 1 / 0", fault, imem_req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    pc = 32'h80; stall = 1'b0;
    cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      n_fail++;
      $display("[TB] FAIL rmf_fetch: req=%0b addr=%h, want 1 / 00000080", imem_req, imem_addr);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0; stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFEBABE;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, pc_sel, fault} !== 5'b0 || instr !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL rmf_after_reset: req=%0b valid=%0b inc=%0b fault=%0b instr=%h, want all 0",
               imem_req, instr_valid, pc_inc, fault, instr);
    end
    cycle();
    imem_ack = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL rmf_late_ack: req=%0b valid=%0b instr=%h, want 0 / 0 / 00000000",
               imem_req, instr_valid, instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    int pulses;
    logic prev_inc;
    do_reset();
    exp_pc = 32'h100; pc = exp_pc; stall = 1'b0;
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'h00000013; instr_ready = 1'b1; branch_taken = 1'b0;
    pulses = 0; prev_inc = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (i % 3 == 0) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
          n_fail++;
          $display("[TB] FAIL b2b_fetch[%0d]: req=%0b addr=%h, want 1 / %h", i, imem_req, imem_addr, exp_pc);
        end
      end
      n_checks++;
      if (prev_inc === 1'b1 && pc_inc === 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_consecutive[%0d]: pc_inc=1 two cycles in a row, want isolated pulses", i);
      end
      if (pc_inc === 1'b1) pulses++;
      prev_inc = pc_inc;
      cycle();
      if (i % 3 == 2) begin
        exp_pc = exp_pc + 32'd4;
        pc = exp_pc;
      end
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("[TB] FAIL b2b_pulses: got %0d pc_inc pulses, want 3", pulses);
    end
  endtask

  initial begin
    reset = 1'b1; pc = '0; stall = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_timeout();
    test_timeout_ack_wins();
    test_misaligned();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
